main_control_fsm: RTL

Multi-cycle main control unit for the Hydra 16-bit datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. In execute it drives the `alu_op`/`alu_opcode` pair consumed by the ALU control decoder. It also issues every register-file, memory and PC strobe, handling a ready-gated memory handshake, branch resolution from the ALU zero flag, illegal-opcode trapping and a retired-instruction counter.

---
 rtl/hydra_ctrl_pkg.sv | 37 +++
 rtl/instr_classifier.sv | 19 +
 rtl/main_control_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hydra_ctrl_pkg.sv
// Shared encodings for the Hydra multi-cycle main control unit.
package hydra_ctrl_pkg;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic is_rtype;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_illegal;
    } instr_class_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational opcode classifier; exactly one class flag is set per opcode.
module instr_classifier
    import hydra_ctrl_pkg::*;
(
    input  logic [3:0]   opcode_i,
    output instr_class_t class_o
);

    always_comb begin
        class_o            = '0;
        class_o.is_rtype   = ~opcode_i[3];
        class_o.is_load    = (opcode_i == OP_LW);
        class_o.is_store   = (opcode_i == OP_SW);
        class_o.is_branch  = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
        class_o.is_jump    = (opcode_i == OP_JMP);
        class_o.is_illegal = (opcode_i > OP_JMP);
    end

endmodule

// File: rtl/main_control_fsm.sv
// Hydra main control: fetch/decode/exec/mem/wb sequencer with a ready-gated
// memory handshake, branch resolution, illegal-opcode trap and retire counter.
module main_control_fsm
    import hydra_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic [3:0]       instr_opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_opcode,
    output logic             alu_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       dbg_state
);

    // Handshake: a memory request (mem_req, mem_we) stays asserted and stable
    // until mem_ready is sampled high; the request completes on that cycle.

    state_t           state_q;
    logic [3:0]       opcode_q;
    logic [CNT_W-1:0] retired_q;
    instr_class_t     cls;
    logic             instr_end;

    instr_classifier u_classifier (
        .opcode_i (opcode_q),
        .class_o  (cls)
    );

    // Last cycle of an instruction: retire and pick FETCH or IDLE.
    assign instr_end = (state_q == WB)
                    || (state_q == MEM  && mem_ready && cls.is_store)
                    || (state_q == EXEC && (cls.is_branch || cls.is_jump));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            opcode_q  <= 4'h0;
            retired_q <= '0;
        end else if (instr_end) begin
            retired_q <= retired_q + CNT_W'(1);
            state_q   <= halt_req ? IDLE : FETCH;
        end else begin
            case (state_q)
                IDLE:   if (start) state_q <= FETCH;
                FETCH:  if (mem_ready) begin
                            opcode_q <= instr_opcode;
                            state_q  <= DECODE;
                        end
                DECODE: state_q <= cls.is_illegal ? TRAP : EXEC;
                EXEC:   state_q <= cls.is_rtype ? WB : MEM;
                MEM:    if (mem_ready) state_q <= WB;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_INC;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PCSRC_INC;
                end
            end
            EXEC: begin
                if (cls.is_rtype) begin
                    alu_op = ALUOP_RTYPE;
                end else if (cls.is_load || cls.is_store) begin
                    alu_op  = ALUOP_ADD;
                    alu_src = 1'b1;
                end else if (cls.is_branch) begin
                    // BEQ takes on zero, BNE on non-zero.
                    alu_op   = ALUOP_SUB;
                    pc_src   = PCSRC_BRANCH;
                    pc_write = alu_zero ~^ (opcode_q == OP_BEQ);
                end else if (cls.is_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = cls.is_store;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.is_rtype;
                mem_to_reg = cls.is_load;
            end
            default: ;
        endcase
    end

    assign alu_opcode = opcode_q;
    assign busy       = (state_q != IDLE) && (state_q != TRAP);
    assign trap       = (state_q == TRAP);
    assign retired    = retired_q;
    assign dbg_state  = state_q;

endmodule
